flood_reveal: RTL and testbench

Flood-fill reveal engine for the minesweeper core: the reader-side counterpart of the mine-placement path. On a player click it reads the mine board (1-bit) and adjacency board (4-bit) through their combinational read ports and performs a breadth-first reveal of connected zero-count cells. Each revealed cell is emitted as a one-cycle write to the display/revealed board. A persistent visited bitmap prevents double reveals across clicks within one game.

---
 rtl/flood_reveal.sv | 188 ++++++++++++++++++
 tb/tb_flood_reveal.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flood_reveal.sv
// Flood-fill reveal engine: breadth-first reveal of connected zero-count cells,
// driving the board read ports and emitting one reveal write per cell.
module flood_reveal #(
  parameter  int width  = 8,
  parameter  int height = 8,
  localparam int XW     = $clog2(width),
  localparam int YW     = $clog2(height),
  localparam int CW     = $clog2(width * height + 1)
) (
  input  logic          clk_tb,
  input  logic          reset_tb,
  input  logic          newGame,
  input  logic          start,
  input  logic [XW-1:0] startX,
  input  logic [YW-1:0] startY,
  output logic [XW-1:0] readX,
  output logic [YW-1:0] readY,
  input  logic          mineValue,
  input  logic [3:0]    adjValue,
  output logic          revealEn,
  output logic [XW-1:0] revealX,
  output logic [YW-1:0] revealY,
  output logic [3:0]    revealAdj,
  output logic          revealMine,
  output logic          busy,
  output logic          done,
  output logic          hitMine,
  output logic [CW-1:0] revealCount
);

  localparam int N  = width * height;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [XW+1:0] XLIM = (XW + 2)'(width);
  localparam logic [YW+1:0] YLIM = (YW + 2)'(height);

  typedef enum logic [2:0] {IDLE, FETCH, SAMPLE, SCAN, FINISH} state_t;

  state_t              state_q;
  logic [N-1:0]        visited_q;
  logic [XW+YW-1:0]    fifo_mem [N];
  logic [PW-1:0]       head_q;
  logic [PW-1:0]       tail_q;
  logic [CW-1:0]       count_q;
  logic [2:0]          nb_q;

  logic [1:0]          ox;
  logic [1:0]          oy;
  logic [XW+1:0]       nx;
  logic [YW+1:0]       ny;
  logic                nb_in;
  logic [PW-1:0]       nb_idx;
  logic [PW-1:0]       start_idx;
  logic                enq_valid;
  logic [XW+YW-1:0]    enq_data;
  logic [PW-1:0]       enq_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(N - 1)) ? '0 : p + 1'b1;
  endfunction

  // Offsets are biased by +1 (0..2); a coordinate of -1 wraps to all ones,
  // so a single unsigned compare against the limit rejects both edges.
  always_comb begin
    ox = 2'd1;
    oy = 2'd1;
    unique case (nb_q)
      3'd0: begin ox = 2'd0; oy = 2'd0; end
      3'd1: begin ox = 2'd1; oy = 2'd0; end
      3'd2: begin ox = 2'd2; oy = 2'd0; end
      3'd3: begin ox = 2'd0; oy = 2'd1; end
      3'd4: begin ox = 2'd2; oy = 2'd1; end
      3'd5: begin ox = 2'd0; oy = 2'd2; end
      3'd6: begin ox = 2'd1; oy = 2'd2; end
      3'd7: begin ox = 2'd2; oy = 2'd2; end
      default: ;
    endcase
  end

  always_comb begin
    nx        = {2'b00, readX} + {{XW{1'b0}}, ox} - (XW + 2)'(1);
    ny        = {2'b00, readY} + {{YW{1'b0}}, oy} - (YW + 2)'(1);
    nb_in     = (nx < XLIM) && (ny < YLIM);
    nb_idx    = PW'(ny[YW-1:0]) * PW'(width) + PW'(nx[XW-1:0]);
    start_idx = PW'(startY) * PW'(width) + PW'(startX);
  end

  // Cells are marked visited on enqueue, so the FIFO can never overflow.
  always_comb begin
    enq_valid = 1'b0;
    enq_data  = '0;
    enq_idx   = '0;
    if (state_q == IDLE && start && !newGame && !visited_q[start_idx]) begin
      enq_valid = 1'b1;
      enq_data  = {startY, startX};
      enq_idx   = start_idx;
    end else if (state_q == SCAN && nb_in && !visited_q[nb_idx]) begin
      enq_valid = 1'b1;
      enq_data  = {ny[YW-1:0], nx[XW-1:0]};
      enq_idx   = nb_idx;
    end
  end

  always_ff @(posedge clk_tb) begin
    if (enq_valid) begin
      fifo_mem[tail_q] <= enq_data;
    end
  end

  always_ff @(posedge clk_tb or negedge reset_tb) begin
    if (!reset_tb) begin
      state_q     <= IDLE;
      visited_q   <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      nb_q        <= '0;
      readX       <= '0;
      readY       <= '0;
      revealEn    <= 1'b0;
      revealX     <= '0;
      revealY     <= '0;
      revealAdj   <= '0;
      revealMine  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hitMine     <= 1'b0;
      revealCount <= '0;
    end else begin
      revealEn <= 1'b0;
      done     <= 1'b0;
      if (enq_valid) begin
        tail_q             <= ptr_inc(tail_q);
        count_q            <= count_q + 1'b1;
        visited_q[enq_idx] <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (newGame) begin
            visited_q <= '0;
          end else if (start) begin
            revealCount <= '0;
            hitMine     <= 1'b0;
            busy        <= 1'b1;
            state_q     <= enq_valid ? FETCH : FINISH;
          end
        end
        FETCH: begin
          {readY, readX} <= fifo_mem[head_q];
          head_q         <= ptr_inc(head_q);
          count_q        <= count_q - 1'b1;
          state_q        <= SAMPLE;
        end
        SAMPLE: begin
          revealEn    <= 1'b1;
          revealX     <= readX;
          revealY     <= readY;
          revealAdj   <= adjValue;
          revealMine  <= mineValue;
          revealCount <= revealCount + 1'b1;
          if (mineValue) begin
            hitMine <= 1'b1;
            state_q <= FINISH;
          end else if (adjValue == 4'd0) begin
            nb_q    <= '0;
            state_q <= SCAN;
          end else begin
            state_q <= (count_q == '0) ? FINISH : FETCH;
          end
        end
        SCAN: begin
          nb_q <= nb_q + 1'b1;
          if (nb_q == 3'd7) begin
            state_q <= (count_q == '0 && !enq_valid) ? FINISH : FETCH;
          end
        end
        FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          head_q  <= tail_q;
          count_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flood_reveal.sv
// Directed bench for flood_reveal on an 8x8 board with a behavioural board model.
module tb_flood_reveal;

  logic       clk_tb = 1'b0;
  logic       reset_tb;
  logic       newGame;
  logic       start;
  logic [2:0] startX, startY;
  logic [2:0] readX, readY;
  logic       mineValue;
  logic [3:0] adjValue;
  logic       revealEn;
  logic [2:0] revealX, revealY;
  logic [3:0] revealAdj;
  logic       revealMine;
  logic       busy;
  logic       done;
  logic       hitMine;
  logic [6:0] revealCount;

  logic       mine_b [64];
  logic [3:0] adj_b  [64];

  int checks = 0;
  int errors = 0;

  int         rev_n, done_n, coinc, first_rev, n_done;
  int         seen [64];
  logic [3:0] last_adj;
  logic       last_mine, timeout, busy_c1, busy_after;
  logic [2:0] last_x, last_y;

  flood_reveal #(.width(8), .height(8)) dut (
    .clk_tb(clk_tb), .reset_tb(reset_tb), .newGame(newGame), .start(start),
    .startX(startX), .startY(startY), .readX(readX), .readY(readY),
    .mineValue(mineValue), .adjValue(adjValue), .revealEn(revealEn),
    .revealX(revealX), .revealY(revealY), .revealAdj(revealAdj),
    .revealMine(revealMine), .busy(busy), .done(done), .hitMine(hitMine),
    .revealCount(revealCount)
  );

  always #5 clk_tb = ~clk_tb;

  always_comb begin
    mineValue = mine_b[{readY, readX}];
    adjValue  = adj_b[{readY, readX}];
  end

  task automatic board_a();
    for (int i = 0; i < 64; i++) begin
      mine_b[i] = 1'b0;
      adj_b[i]  = 4'd0;
    end
    mine_b[0]  = 1'b1;
    adj_b[1]   = 4'd1;
    adj_b[8]   = 4'd1;
    adj_b[9]   = 4'd1;
  endtask

  task automatic board_empty();
    for (int i = 0; i < 64; i++) begin
      mine_b[i] = 1'b0;
      adj_b[i]  = 4'd0;
    end
  endtask

  task automatic new_game();
    @(negedge clk_tb);
    newGame = 1'b1;
    @(negedge clk_tb);
    newGame = 1'b0;
  endtask

  // Cycle n is the interval after the n-th rising edge, edge 0 accepting start.
  task automatic click(input int x, input int y, input int inject);
    rev_n = 0; done_n = 0; coinc = 0; first_rev = -1; n_done = -1;
    timeout = 1'b1; busy_c1 = 1'b0; busy_after = 1'b1;
    last_adj = '0; last_mine = 1'b0; last_x = '0; last_y = '0;
    for (int i = 0; i < 64; i++) seen[i] = 0;
    @(negedge clk_tb);
    start  = 1'b1;
    startX = 3'(x);
    startY = 3'(y);
    @(posedge clk_tb);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_tb);
      if (n == 0) start = 1'b0;
      if (n == inject) begin
        start = 1'b1; startX = 3'd3; startY = 3'd4;
      end
      if (n == inject + 1) start = 1'b0;
      if (n == 1) busy_c1 = busy;
      if (revealEn) begin
        rev_n++;
        seen[{revealY, revealX}]++;
        last_adj = revealAdj; last_mine = revealMine;
        last_x = revealX; last_y = revealY;
        if (first_rev < 0) first_rev = n;
      end
      if (done) begin
        done_n++;
        if (n_done < 0) n_done = n;
      end
      if (revealEn && done) coinc++;
      if (n_done >= 0 && n == n_done + 3) begin
        busy_after = busy;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_tb = 1'b0; newGame = 1'b0; start = 1'b0; startX = '0; startY = '0;
    board_a();
    #12;
    checks++;
    if ({busy, done, revealEn, hitMine} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=0000", {busy, done, revealEn, hitMine});
    end
    checks++;
    if ({readX, readY, revealX, revealY, revealAdj, revealMine, revealCount} !== 24'd0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0", {readX, readY, revealX, revealY, revealAdj, revealMine, revealCount});
    end
    @(negedge clk_tb);
    reset_tb = 1'b1;
  endtask

  task automatic test_flood_a();
    int bad;
    board_a();
    new_game();
    click(7, 7, -1);
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL flood_a_timeout got=1 want=0"); end
    checks++;
    if (rev_n != 63) begin errors++; $display("FAIL flood_a_writes got=%0d want=63", rev_n); end
    bad = 0;
    for (int i = 1; i < 64; i++) if (seen[i] != 1) bad++;
    if (seen[0] != 0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL flood_a_coverage got=%0d bad cells want=0", bad); end
    checks++;
    if (revealCount !== 7'd63) begin errors++; $display("FAIL flood_a_count got=%0d want=63", revealCount); end
    checks++;
    if (hitMine !== 1'b0) begin errors++; $display("FAIL flood_a_hitmine got=%b want=0", hitMine); end
    checks++;
    if (coinc != 0 || done_n != 1) begin
      errors++; $display("FAIL flood_a_done got=coinc %0d dones %0d want=0 1", coinc, done_n);
    end
  endtask

  task automatic test_single_nonzero();
    board_a();
    new_game();
    click(1, 1, -1);
    checks++;
    if (n_done != 3) begin errors++; $display("FAIL single_done_cycle got=%0d want=3", n_done); end
    checks++;
    if (first_rev != 2) begin errors++; $display("FAIL single_reveal_cycle got=%0d want=2", first_rev); end
    checks++;
    if (rev_n != 1 || last_x !== 3'd1 || last_y !== 3'd1) begin
      errors++; $display("FAIL single_write got=%0d@(%0d,%0d) want=1@(1,1)", rev_n, last_x, last_y);
    end
    checks++;
    if (last_adj !== 4'd1 || last_mine !== 1'b0) begin
      errors++; $display("FAIL single_data got=adj %0d mine %b want=adj 1 mine 0", last_adj, last_mine);
    end
    checks++;
    if (revealCount !== 7'd1) begin errors++; $display("FAIL single_count got=%0d want=1", revealCount); end
    checks++;
    if (busy_c1 !== 1'b1 || busy_after !== 1'b0) begin
      errors++; $display("FAIL single_busy got=%b%b want=10", busy_c1, busy_after);
    end
  endtask

  task automatic test_mine();
    board_a();
    new_game();
    click(0, 0, -1);
    checks++;
    if (rev_n != 1 || last_mine !== 1'b1) begin
      errors++; $display("FAIL mine_write got=%0d mine %b want=1 mine 1", rev_n, last_mine);
    end
    checks++;
    if (hitMine !== 1'b1) begin errors++; $display("FAIL mine_hit got=%b want=1", hitMine); end
    checks++;
    if (revealCount !== 7'd1) begin errors++; $display("FAIL mine_count got=%0d want=1", revealCount); end
  endtask

  task automatic test_visited();
    board_a();
    new_game();
    click(7, 7, -1);
    checks++;
    if (hitMine !== 1'b0) begin errors++; $display("FAIL visited_hitmine_clear got=%b want=0", hitMine); end
    click(3, 3, -1);
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL visited_done_cycle got=%0d want=1", n_done); end
    checks++;
    if (rev_n != 0 || revealCount !== 7'd0) begin
      errors++; $display("FAIL visited_writes got=%0d count %0d want=0 0", rev_n, revealCount);
    end
    new_game();
    click(3, 3, -1);
    checks++;
    if (rev_n != 63 || revealCount !== 7'd63) begin
      errors++; $display("FAIL visited_regame got=%0d count %0d want=63 63", rev_n, revealCount);
    end
  endtask

  task automatic test_empty_board();
    int bad;
    board_empty();
    new_game();
    click(0, 0, 50);
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL empty_timeout got=1 want=0"); end
    checks++;
    if (rev_n != 64 || revealCount !== 7'd64) begin
      errors++; $display("FAIL empty_writes got=%0d count %0d want=64 64", rev_n, revealCount);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (seen[i] != 1) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL empty_coverage got=%0d bad cells want=0", bad); end
    checks++;
    if (done_n != 1 || coinc != 0) begin
      errors++; $display("FAIL empty_done got=dones %0d coinc %0d want=1 0", done_n, coinc);
    end
  endtask

  task automatic test_reset_mid_flood();
    board_a();
    new_game();
    @(negedge clk_tb);
    start = 1'b1; startX = 3'd7; startY = 3'd7;
    @(negedge clk_tb);
    start = 1'b0;
    repeat (40) @(negedge clk_tb);
    #2 reset_tb = 1'b0;
    #1;
    checks++;
    if ({busy, done, revealEn, hitMine} !== 4'b0000) begin
      errors++; $display("FAIL midreset_flags got=%b want=0000", {busy, done, revealEn, hitMine});
    end
    checks++;
    if ({readX, readY, revealX, revealY, revealAdj, revealMine, revealCount} !== 24'd0) begin
      errors++;
      $display("FAIL midreset_data got=%h want=0", {readX, readY, revealX, revealY, revealAdj, revealMine, revealCount});
    end
    @(negedge clk_tb);
    reset_tb = 1'b1;
    click(5, 5, -1);
    checks++;
    if (rev_n != 63 || revealCount !== 7'd63 || seen[0] != 0) begin
      errors++; $display("FAIL midreset_reflood got=%0d count %0d want=63 63", rev_n, revealCount);
    end
  endtask

  initial begin
    test_reset();
    test_flood_a();
    test_single_nonzero();
    test_mine();
    test_visited();
    test_empty_board();
    test_reset_mid_flood();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
